lc3_datapath_mem: RTL
=====================

// Module: lc3_datapath_mem
// PURPOSE
//  Parametrised LC-3 datapath: PC/IR/MAR/MDR, 8-entry register file, ALU, address adder, one-hot bus, NZP, BEN, LED latch.
//  Adds a request/acknowledge memory port with wait states, a timeout, and bus-contention detection.
//  Sits between the control FSM, which drives LD_*/Gate*/mux selects and Mem_*_Req, and external SRAM/IO.
// PARAMETERS
//  DATA_W      16       datapath width, >=16; IR fields at LC-3 bit positions, SEXT fills to DATA_W
//  PC_RESET    'h3000   PC value on reset
//  LED_W       12       LED width, <=DATA_W; LED <= IR[LED_W-1:0]
//  MEM_TIMEOUT 255      max wait cycles per memory access before abort, >=1
// PORTS
//  Clk          in  1      clock, rising edge
//  Reset_al     in  1      asynchronous reset, active-low
//  LD_PC,LD_IR,LD_MAR,LD_MDR,LD_REG,LD_CC,LD_BEN,LD_LED  in 1 each  register loads
//  GatePC,GateMDR,GateALU,GateMARMUX  in 1 each  bus drivers; one-hot expected
//  PCMUX        in  2      00 PC+1, 01 BUS, 10 ADDER, 11 hold
//  ADDR1MUX     in  1      0 PC, 1 SR1
//  ADDR2MUX     in  2      00 zero, 01 SEXT(IR[5:0]), 10 SEXT(IR[8:0]), 11 SEXT(IR[10:0])
//  SR1MUX       in  1      0 IR[8:6], 1 IR[11:9]
//  DRMUX        in  1      0 IR[11:9], 1 R7
//  ALUK         in  2      00 ADD, 01 AND, 10 NOT A, 11 PASS A
//  Mem_Rd_Req, Mem_Wr_Req in 1  start read/write at MAR (sampled in IDLE only)
//  Err_Clr      in  1      clears Mem_Err and Bus_Err
//  Mem_Ack      in  1      memory completes current access
//  Mem_Rdata    in  DATA_W read data, valid with Mem_Ack
//  Mem_Addr, Mem_Wdata  out DATA_W  = MAR, MDR
//  Mem_Rd, Mem_Wr       out 1       high for the whole RD / WR state
//  Mem_Busy     out 1      FSM not IDLE
//  Mem_Done     out 1      one-cycle pulse after successful access
//  Mem_Err, Bus_Err  out 1 sticky: timeout/illegal request; multiple gates on one edge
//  IR, PC, MAR, MDR  out DATA_W;  NZP out 3;  BEN out 1;  LED out LED_W
// BEHAVIOUR
//  Reset (async, Reset_al=0): PC=PC_RESET; IR, MAR, MDR, R0-R7, LED, BEN = 0; NZP=3'b010; FSM=IDLE;
//   all Mem_* outputs, Mem_Err, Bus_Err = 0. Reset mid-access drops Mem_Rd/Mem_Wr immediately.
//  BUS: value of the single asserted gate; none -> 0; >1 gate -> BUS=0, Bus_Err set on that edge.
//  ALU B operand: IR[5] ? SEXT(IR[4:0]) : SR2 (IR[2:0]). ADD/ADDER are modulo 2^DATA_W, carry discarded.
//  All loads are registered on the rising edge; register file has 2 asynchronous read ports and 1 write port (BUS->DR on LD_REG).
//  LD_CC: exactly one NZP bit set from BUS (N=BUS[MSB]; Z=BUS==0; P otherwise).
//  LD_BEN: BEN <= (IR[11]&N)|(IR[10]&Z)|(IR[9]&P), using currently registered NZP.
//  Memory FSM states IDLE, RD, WR:
//   IDLE: Rd_Req only -> RD; Wr_Req only -> WR; both -> stay IDLE, set Mem_Err. Mem_Ack ignored.
//   RD/WR: wait counter starts at 0 on entry, +1 per cycle without Ack.
//    Ack -> IDLE; in RD, MDR <= Mem_Rdata on the same edge; Mem_Done=1 the next cycle.
//    Counter reaches MEM_TIMEOUT with no Ack -> IDLE, set Mem_Err, MDR unchanged, no Mem_Done. Ack on the expiry cycle wins.
//   Requests while busy are ignored (no queueing, no error).
//   While busy: LD_MAR and LD_MDR are ignored, so address and write data stay stable.
//  Minimum access: request at edge k, Ack sampled at edge k+1, MDR valid and Mem_Done high after edge k+1.
//  Err_Clr: clears both sticky flags on the next edge; a simultaneous new error wins (flag stays set).
// TESTING
//  Reset: Reset_al=0 mid-RD -> PC=0x3000, NZP=010, Mem_Rd=0 within the same cycle, Busy=0.
//  Fetch: MAR=0x3000, Rd_Req, Ack after 3 waits, Rdata=0x1261 -> MDR=0x1261, Done 1 cycle; GateMDR+LD_IR -> IR=0x1261.
//  ALU/CC: R1=0x7FFF, ADD R1,R1,#1 with LD_CC -> R1=0x8000, NZP=100; AND with #0 -> 0x0000, NZP=010.
//  BEN: IR=0x0A05 (BRnp), NZP=010 -> BEN=0; NZP=001 -> BEN=1; PCMUX=10, ADDR2=10 -> PC=PC+5.
//  Timeout: MEM_TIMEOUT=4, no Ack -> Busy for 5 cycles, Mem_Err=1, MDR unchanged; Ack on expiry cycle -> no error.
//  Contention/illegal: GatePC+GateALU -> BUS=0, Bus_Err=1; Rd_Req+Wr_Req in IDLE -> Mem_Err=1; Err_Clr clears both.

Source files
------------

// File: rtl/lc3_datapath_mem.sv
// rtl/lc3_datapath_mem.sv - LC-3 datapath with handshaked memory port, timeout and bus-contention detection
module lc3_datapath_mem #(
  parameter int                  DATA_W      = 16,
  parameter logic [DATA_W-1:0]   PC_RESET    = 'h3000,
  parameter int                  LED_W       = 12,
  parameter int                  MEM_TIMEOUT = 255
) (
  input  logic              Clk,
  input  logic              Reset_al,
  input  logic              LD_PC,
  input  logic              LD_IR,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              LD_REG,
  input  logic              LD_CC,
  input  logic              LD_BEN,
  input  logic              LD_LED,
  input  logic              GatePC,
  input  logic              GateMDR,
  input  logic              GateALU,
  input  logic              GateMARMUX,
  input  logic [1:0]        PCMUX,
  input  logic              ADDR1MUX,
  input  logic [1:0]        ADDR2MUX,
  input  logic              SR1MUX,
  input  logic              DRMUX,
  input  logic [1:0]        ALUK,
  input  logic              Mem_Rd_Req,
  input  logic              Mem_Wr_Req,
  input  logic              Err_Clr,
  input  logic              Mem_Ack,
  input  logic [DATA_W-1:0] Mem_Rdata,
  output logic [DATA_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_Wdata,
  output logic              Mem_Rd,
  output logic              Mem_Wr,
  output logic              Mem_Busy,
  output logic              Mem_Done,
  output logic              Mem_Err,
  output logic              Bus_Err,
  output logic [DATA_W-1:0] IR,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] MAR,
  output logic [DATA_W-1:0] MDR,
  output logic [2:0]        NZP,
  output logic              BEN,
  output logic [LED_W-1:0]  LED
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} mem_state_e;

  mem_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              done_q, mem_err_q, bus_err_q;
  logic              mem_err_d, bus_err_d;
  logic [DATA_W-1:0] pc_q, ir_q, mar_q, mdr_q;
  logic [DATA_W-1:0] regs_q [8];
  logic [2:0]        nzp_q;
  logic              ben_q;
  logic [LED_W-1:0]  led_q;

  logic [2:0]        sr1_sel, dr_sel;
  logic [DATA_W-1:0] sr1_val, sr2_val, alu_b, alu_out;
  logic [DATA_W-1:0] addr1, addr2, adder_out, pc_d, bus;
  logic              contention, busy, expired;
  logic              unused_ir;

  assign sr1_sel = SR1MUX ? ir_q[11:9] : ir_q[8:6];
  assign dr_sel  = DRMUX ? 3'd7 : ir_q[11:9];
  assign sr1_val = regs_q[sr1_sel];
  assign sr2_val = regs_q[ir_q[2:0]];
  assign alu_b   = ir_q[5] ? {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]} : sr2_val;

  always_comb begin
    alu_out = '0;
    case (ALUK)
      2'b00:   alu_out = sr1_val + alu_b;
      2'b01:   alu_out = sr1_val & alu_b;
      2'b10:   alu_out = ~sr1_val;
      default: alu_out = sr1_val;
    endcase
  end

  assign addr1 = ADDR1MUX ? sr1_val : pc_q;

  always_comb begin
    addr2 = '0;
    case (ADDR2MUX)
      2'b00:   addr2 = '0;
      2'b01:   addr2 = {{(DATA_W-6){ir_q[5]}}, ir_q[5:0]};
      2'b10:   addr2 = {{(DATA_W-9){ir_q[8]}}, ir_q[8:0]};
      default: addr2 = {{(DATA_W-11){ir_q[10]}}, ir_q[10:0]};
    endcase
  end

  assign adder_out = addr1 + addr2;

  // More than one driver forces the bus to zero rather than picking a winner.
  always_comb begin
    bus        = '0;
    contention = 1'b0;
    case ({GatePC, GateMDR, GateALU, GateMARMUX})
      4'b0000: bus = '0;
      4'b1000: bus = pc_q;
      4'b0100: bus = mdr_q;
      4'b0010: bus = alu_out;
      4'b0001: bus = adder_out;
      default: contention = 1'b1;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    case (PCMUX)
      2'b00:   pc_d = pc_q + 1'b1;
      2'b01:   pc_d = bus;
      2'b10:   pc_d = adder_out;
      default: pc_d = pc_q;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign expired = busy && !Mem_Ack && (cnt_q == CNT_W'(MEM_TIMEOUT));

  always_comb begin
    mem_err_d = (mem_err_q & ~Err_Clr) |
                ((state_q == S_IDLE) & Mem_Rd_Req & Mem_Wr_Req) | expired;
    bus_err_d = (bus_err_q & ~Err_Clr) | contention;
  end

  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      pc_q  <= PC_RESET;
      ir_q  <= '0;
      mar_q <= '0;
      nzp_q <= 3'b010;
      ben_q <= 1'b0;
      led_q <= '0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      if (LD_PC)  pc_q <= pc_d;
      if (LD_IR)  ir_q <= bus;
      if (LD_MAR && !busy) mar_q <= bus;
      if (LD_REG) regs_q[dr_sel] <= bus;
      if (LD_CC) begin
        nzp_q <= bus[DATA_W-1] ? 3'b100 : ((bus == '0) ? 3'b010 : 3'b001);
      end
      if (LD_BEN) ben_q <= (ir_q[11] & nzp_q[2]) | (ir_q[10] & nzp_q[1]) | (ir_q[9] & nzp_q[0]);
      if (LD_LED) led_q <= ir_q[LED_W-1:0];
    end
  end

  // MDR lives here because the memory FSM and the bus both load it.
  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      mem_err_q <= 1'b0;
      bus_err_q <= 1'b0;
      mdr_q     <= '0;
    end else begin
      done_q    <= 1'b0;
      mem_err_q <= mem_err_d;
      bus_err_q <= bus_err_d;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (LD_MDR) mdr_q <= bus;
          if (Mem_Rd_Req && !Mem_Wr_Req)      state_q <= S_RD;
          else if (Mem_Wr_Req && !Mem_Rd_Req) state_q <= S_WR;
        end
        S_RD, S_WR: begin
          if (Mem_Ack) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            if (state_q == S_RD) mdr_q <= Mem_Rdata;
          end else if (expired) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign unused_ir = ^ir_q[DATA_W-1:12];

  assign Mem_Addr  = mar_q;
  assign Mem_Wdata = mdr_q;
  assign Mem_Rd    = (state_q == S_RD);
  assign Mem_Wr    = (state_q == S_WR);
  assign Mem_Busy  = busy;
  assign Mem_Done  = done_q;
  assign Mem_Err   = mem_err_q;
  assign Bus_Err   = bus_err_q;
  assign IR        = ir_q;
  assign PC        = pc_q;
  assign MAR       = mar_q;
  assign MDR       = mdr_q;
  assign NZP       = nzp_q;
  assign BEN       = ben_q;
  assign LED       = led_q;

endmodule
